gat_bram_loader: RTL and testbench

Stream-to-BRAM loader that sits directly upstream of the GAT accelerator top. It accepts one AXI-Stream transfer from the host DMA and splits it, in fixed order, into the H sparse-data BRAM, the H node-info BRAM and the weight BRAM. It drives each BRAM's write port and raises the matching `*_load_done` flag that the accelerator waits on before starting a layer.

---
 rtl/gat_pkg.sv | 18 +
 rtl/gat_bram_loader_if.sv | 43 ++++
 rtl/gat_load_wr_port.sv | 28 ++
 rtl/gat_bram_loader.sv | 128 ++++++++++++
 tb/tb_gat_bram_loader.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/gat_pkg.sv
// gat_pkg: loader FSM state type and default GAT geometry shared with the accelerator top.
package gat_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_H, LOAD_NODE, LOAD_WGT, DONE} loader_state_t;

    localparam int DEF_S_DATA_WIDTH    = 32;
    localparam int DEF_H_DATA_WIDTH    = 19;
    localparam int DEF_NODE_INFO_WIDTH = 20;
    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_H_DATA_DEPTH    = 242101;
    localparam int DEF_NODE_INFO_DEPTH = 13264;
    localparam int DEF_WEIGHT_DEPTH    = 22928;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/gat_bram_loader_if.sv
// gat_bram_loader_if: host AXI-Stream input plus the three BRAM write ports fed by the loader.
interface gat_bram_loader_if #(
    parameter int S_DATA_WIDTH     = gat_pkg::DEF_S_DATA_WIDTH,
    parameter int H_DATA_WIDTH     = gat_pkg::DEF_H_DATA_WIDTH,
    parameter int NODE_INFO_WIDTH  = gat_pkg::DEF_NODE_INFO_WIDTH,
    parameter int DATA_WIDTH       = gat_pkg::DEF_DATA_WIDTH,
    parameter int H_DATA_ADDR_W    = $clog2(gat_pkg::DEF_H_DATA_DEPTH),
    parameter int NODE_INFO_ADDR_W = $clog2(gat_pkg::DEF_NODE_INFO_DEPTH),
    parameter int WEIGHT_ADDR_W    = $clog2(gat_pkg::DEF_WEIGHT_DEPTH)
);
    logic [S_DATA_WIDTH-1:0]     s_axis_tdata;
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic                        s_axis_tlast;
    logic [H_DATA_WIDTH-1:0]     h_data_bram_din;
    logic                        h_data_bram_ena;
    logic                        h_data_bram_wea;
    logic [H_DATA_ADDR_W-1:0]    h_data_bram_addra;
    logic [NODE_INFO_WIDTH-1:0]  h_node_info_bram_din;
    logic                        h_node_info_bram_ena;
    logic                        h_node_info_bram_wea;
    logic [NODE_INFO_ADDR_W-1:0] h_node_info_bram_addra;
    logic [DATA_WIDTH-1:0]       wgt_bram_din;
    logic                        wgt_bram_ena;
    logic                        wgt_bram_wea;
    logic [WEIGHT_ADDR_W-1:0]    wgt_bram_addra;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
        input  h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
        input  wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
        output h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
        output wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra
    );
endinterface

// File: rtl/gat_load_wr_port.sv
// gat_load_wr_port: registered BRAM write-port driver; enable pulses for one cycle per accepted word.
module gat_load_wr_port #(
    parameter int DW = 8,
    parameter int AW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic          en,
    output logic [AW-1:0] addr_q,
    output logic [DW-1:0] din_q
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en     <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            en <= we;
            if (we) begin
                addr_q <= addr;
                din_q  <= din;
            end
        end
    end
endmodule

// File: rtl/gat_bram_loader.sv
// gat_bram_loader: splits one stream transfer into H data, node-info and weight BRAMs in that order.
// Define GAT_LOADER_TLAST_CHECK_EN to flag misplaced/missing tlast on load_err.
module gat_bram_loader import gat_pkg::*; #(
    parameter int S_DATA_WIDTH     = DEF_S_DATA_WIDTH,
    parameter int H_DATA_WIDTH     = DEF_H_DATA_WIDTH,
    parameter int NODE_INFO_WIDTH  = DEF_NODE_INFO_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int H_DATA_DEPTH     = DEF_H_DATA_DEPTH,
    parameter int NODE_INFO_DEPTH  = DEF_NODE_INFO_DEPTH,
    parameter int WEIGHT_DEPTH     = DEF_WEIGHT_DEPTH,
    parameter int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
    parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
    parameter int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    gat_bram_loader_if.slave   bus,
    output logic               h_data_bram_load_done,
    output logic               h_node_info_bram_load_done,
    output logic               wgt_bram_load_done,
    output logic               load_busy,
    output logic               load_err
);
    localparam int CNT_RAW = max3(H_DATA_ADDR_W, NODE_INFO_ADDR_W, WEIGHT_ADDR_W);
    localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;

    loader_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       seg_end;
    logic             tready;
    logic             hs;
    logic             seg_last;
    logic             start_ok;
    logic             unused_bits;

    assign bus.s_axis_tready = tready;
    assign hs       = bus.s_axis_tvalid & tready;
    assign start_ok = load_start && (state == IDLE || state == DONE);
    assign seg_last = (state == LOAD_H)    ? cnt == CNT_W'(H_DATA_DEPTH - 1) :
                      (state == LOAD_NODE) ? cnt == CNT_W'(NODE_INFO_DEPTH - 1) :
                                             cnt == CNT_W'(WEIGHT_DEPTH - 1);
    assign unused_bits = &{1'b0, bus.s_axis_tdata, bus.s_axis_tlast};

    // seg_end delays each segment's done flag one cycle past its final write strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                      <= IDLE;
            cnt                        <= '0;
            tready                     <= 1'b0;
            load_busy                  <= 1'b0;
            seg_end                    <= '0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done         <= 1'b0;
        end else begin
            seg_end <= '0;
            if (seg_end[0]) h_data_bram_load_done <= 1'b1;
            if (seg_end[1]) h_node_info_bram_load_done <= 1'b1;
            if (seg_end[2]) begin
                wgt_bram_load_done <= 1'b1;
                load_busy          <= 1'b0;
            end
            if (start_ok) begin
                state                      <= LOAD_H;
                cnt                        <= '0;
                tready                     <= 1'b1;
                load_busy                  <= 1'b1;
                h_data_bram_load_done      <= 1'b0;
                h_node_info_bram_load_done <= 1'b0;
                wgt_bram_load_done         <= 1'b0;
            end else if (hs) begin
                cnt <= seg_last ? '0 : cnt + 1'b1;
                if (seg_last) begin
                    seg_end <= {state == LOAD_WGT, state == LOAD_NODE, state == LOAD_H};
                    state   <= (state == LOAD_H) ? LOAD_NODE : (state == LOAD_NODE) ? LOAD_WGT : DONE;
                    tready  <= state != LOAD_WGT;
                end
            end
        end
    end

`ifdef GAT_LOADER_TLAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) load_err <= 1'b0;
        else if (hs && (bus.s_axis_tlast != (state == LOAD_WGT && seg_last))) load_err <= 1'b1;
    end
`else
    assign load_err = 1'b0;
`endif

    gat_load_wr_port #(.DW(H_DATA_WIDTH), .AW(H_DATA_ADDR_W)) u_h_data (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (hs && state == LOAD_H),
        .addr   (cnt[H_DATA_ADDR_W-1:0]),
        .din    (bus.s_axis_tdata[H_DATA_WIDTH-1:0]),
        .en     (bus.h_data_bram_ena),
        .addr_q (bus.h_data_bram_addra),
        .din_q  (bus.h_data_bram_din)
    );

    gat_load_wr_port #(.DW(NODE_INFO_WIDTH), .AW(NODE_INFO_ADDR_W)) u_node_info (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (hs && state == LOAD_NODE),
        .addr   (cnt[NODE_INFO_ADDR_W-1:0]),
        .din    (bus.s_axis_tdata[NODE_INFO_WIDTH-1:0]),
        .en     (bus.h_node_info_bram_ena),
        .addr_q (bus.h_node_info_bram_addra),
        .din_q  (bus.h_node_info_bram_din)
    );

    gat_load_wr_port #(.DW(DATA_WIDTH), .AW(WEIGHT_ADDR_W)) u_wgt (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (hs && state == LOAD_WGT),
        .addr   (cnt[WEIGHT_ADDR_W-1:0]),
        .din    (bus.s_axis_tdata[DATA_WIDTH-1:0]),
        .en     (bus.wgt_bram_ena),
        .addr_q (bus.wgt_bram_addra),
        .din_q  (bus.wgt_bram_din)
    );

    assign bus.h_data_bram_wea      = bus.h_data_bram_ena;
    assign bus.h_node_info_bram_wea = bus.h_node_info_bram_ena;
    assign bus.wgt_bram_wea         = bus.wgt_bram_ena;
endmodule

// File: tb/tb_gat_bram_loader.sv
// tb_gat_bram_loader: directed loads with a write/done-flag scoreboard; depths 4/3/2.
module tb_gat_bram_loader;
`ifdef GAT_LOADER_TLAST_CHECK_EN
    localparam logic TL = 1'b1;
`else
    localparam logic TL = 1'b0;
`endif

    typedef struct {
        int          port;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0;
    logic h_done, n_done, w_done, load_busy, load_err;
    logic [2:0] prev_done = 3'b000;
    int cyc = 0;
    int passed = 0;
    int total = 0;
    wr_t sq[$];
    int dq0[$], dq1[$], dq2[$];

    gat_bram_loader_if #(
        .S_DATA_WIDTH(32), .H_DATA_WIDTH(19), .NODE_INFO_WIDTH(20), .DATA_WIDTH(8),
        .H_DATA_ADDR_W(2), .NODE_INFO_ADDR_W(2), .WEIGHT_ADDR_W(1)
    ) bus ();

    gat_bram_loader #(
        .S_DATA_WIDTH(32), .H_DATA_WIDTH(19), .NODE_INFO_WIDTH(20), .DATA_WIDTH(8),
        .H_DATA_DEPTH(4), .NODE_INFO_DEPTH(3), .WEIGHT_DEPTH(2)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .load_start                 (load_start),
        .bus                        (bus),
        .h_data_bram_load_done      (h_done),
        .h_node_info_bram_load_done (n_done),
        .wgt_bram_load_done         (w_done),
        .load_busy                  (load_busy),
        .load_err                   (load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] msk(input int p);
        return (p == 0) ? 32'h7_FFFF : (p == 1) ? 32'hF_FFFF : 32'hFF;
    endfunction

    task automatic pop_wr(input int p, input int a, input logic [31:0] d);
        wr_t e;
        if (sq.size() == 0) begin
            chk("wr_unexpected", 32'(p), 32'hFFFF_FFFF);
        end else begin
            e = sq.pop_front();
            chk("wr_port", 32'(p), 32'(e.port));
            chk("wr_addr", 32'(a), 32'(e.addr));
            chk("wr_data", d, e.data);
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    task automatic pop_done(input int p);
        int c;
        c = -1;
        if (p == 0 && dq0.size() > 0) c = dq0.pop_front();
        if (p == 1 && dq1.size() > 0) c = dq1.pop_front();
        if (p == 2 && dq2.size() > 0) c = dq2.pop_front();
        chk("done_rise_cycle", 32'(cyc), 32'(c));
        if (p == 2) chk("busy_fall_with_wgt_done", 32'(load_busy), 32'd0);
    endtask

    // monitor: every write strobe and done-flag rise is matched against the scoreboard
    always @(negedge clk) begin
        int n;
        n = int'(bus.h_data_bram_ena === 1'b1) + int'(bus.h_node_info_bram_ena === 1'b1) + int'(bus.wgt_bram_ena === 1'b1);
        if (n > 0) begin
            chk("one_port_enabled", 32'(n), 32'd1);
            chk("ena_eq_wea", {29'd0, bus.h_data_bram_wea, bus.h_node_info_bram_wea, bus.wgt_bram_wea},
                {29'd0, bus.h_data_bram_ena, bus.h_node_info_bram_ena, bus.wgt_bram_ena});
        end
        if (bus.h_data_bram_ena === 1'b1) pop_wr(0, int'(bus.h_data_bram_addra), 32'(bus.h_data_bram_din));
        if (bus.h_node_info_bram_ena === 1'b1) pop_wr(1, int'(bus.h_node_info_bram_addra), 32'(bus.h_node_info_bram_din));
        if (bus.wgt_bram_ena === 1'b1) pop_wr(2, int'(bus.wgt_bram_addra), 32'(bus.wgt_bram_din));
        if (h_done === 1'b1 && !prev_done[0]) pop_done(0);
        if (n_done === 1'b1 && !prev_done[1]) pop_done(1);
        if (w_done === 1'b1 && !prev_done[2]) pop_done(2);
        prev_done = {w_done === 1'b1, n_done === 1'b1, h_done === 1'b1};
    end

    task automatic run_load(input logic [31:0] base, input logic gap, input logic ff,
                            input int tlast_at, input int start_at, input int nb);
        logic [31:0] v;
        int p, a;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk("start_tready", 32'(bus.s_axis_tready), 32'd1);
        chk("start_busy", 32'(load_busy), 32'd1);
        chk("start_err_clear", 32'(load_err), 32'd0);
        chk("start_done_clear", {29'd0, w_done, n_done, h_done}, 32'd0);
        for (int k = 0; k < nb; k++) begin
            if (gap && k > 0) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            v = ff ? 32'hFFFF_FFFF : base + 32'(k);
            bus.s_axis_tdata  = v;
            bus.s_axis_tlast  = (k == tlast_at);
            bus.s_axis_tvalid = 1'b1;
            load_start        = (k == start_at);
            @(posedge clk); #1;
            load_start = 1'b0;
            p = (k < 4) ? 0 : (k < 7) ? 1 : 2;
            a = (k < 4) ? k : (k < 7) ? k - 4 : k - 7;
            sq.push_back('{p, a, v & msk(p), cyc});
            if (k == 3) dq0.push_back(cyc + 1);
            if (k == 6) dq1.push_back(cyc + 1);
            if (k == 8) dq2.push_back(cyc + 1);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (nb == 9) begin
            chk("end_tready_low", 32'(bus.s_axis_tready), 32'd0);
            chk("end_busy_still_high", 32'(load_busy), 32'd1);
        end
    endtask

    task automatic finish_check(input logic exp_err);
        repeat (3) @(posedge clk);
        #1;
        chk("all_done_flags", {29'd0, w_done, n_done, h_done}, 32'h7);
        chk("idle_busy", 32'(load_busy), 32'd0);
        chk("idle_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("load_err", 32'(load_err), 32'(exp_err));
    endtask

    task automatic check_reset_outputs();
        chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("rst_busy_err", {30'd0, load_busy, load_err}, 32'd0);
        chk("rst_done", {29'd0, w_done, n_done, h_done}, 32'd0);
        chk("rst_ena_wea", {26'd0, bus.h_data_bram_ena, bus.h_data_bram_wea, bus.h_node_info_bram_ena,
            bus.h_node_info_bram_wea, bus.wgt_bram_ena, bus.wgt_bram_wea}, 32'd0);
        chk("rst_addr", {27'd0, bus.h_data_bram_addra, bus.h_node_info_bram_addra, bus.wgt_bram_addra}, 32'd0);
        chk("rst_din", 32'(bus.h_data_bram_din) | 32'(bus.h_node_info_bram_din) | 32'(bus.wgt_bram_din), 32'd0);
    endtask

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();

        run_load(32'h10, 1'b0, 1'b0, 8, -1, 9);
        finish_check(1'b0);
        run_load(32'h10, 1'b1, 1'b0, 8, -1, 9);
        finish_check(1'b0);
        run_load(32'h20, 1'b0, 1'b0, 8, 5, 9);
        finish_check(1'b0);

        run_load(32'h30, 1'b0, 1'b0, 8, -1, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_outputs();
        run_load(32'h50, 1'b0, 1'b0, 8, -1, 9);
        finish_check(1'b0);

        run_load(32'h60, 1'b0, 1'b0, 2, -1, 9);
        finish_check(TL);
        run_load(32'h0, 1'b0, 1'b1, 8, -1, 9);
        finish_check(1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sq.size() + dq0.size() + dq1.size() + dq2.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
